dh_exchange_sequencer: RTL and testbench
========================================

Name: dh_exchange_sequencer

Overview:
- Control FSM that sequences one Diffie-Hellman key exchange through a single shared modular-exponentiation engine.
- Phase 1 computes the local public key G^X mod P and publishes it. Phase 2 waits for the peer public key Y, then computes the shared secret Y^X mod P on OUT.
- Sits between the top-level start/operand inputs and the modexp datapath. Owns the engine handshake, operand muxing, and a per-run timeout.

Parameters:
- WIDTH, 32, width of G, P, X, peer key and engine operands
- OUT_W, 48, width of engine result and OUT
- TMO_W, 16, width of engine timeout counter
- TMO_MAX, 16'hFFFF, cycles allowed from eng_start to eng_done before error

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous active-low reset
- ST  in  1  start request; rising edge detected internally
- G  in  WIDTH  generator
- P  in  WIDTH  modulus
- X  in  WIDTH  local private exponent
- peer_vld  in  1  peer public key valid, single-cycle or level
- peer_pub  in  WIDTH  peer public key Y
- eng_start  out  1  one-cycle engine start pulse
- eng_base  out  WIDTH  engine base operand
- eng_exp  out  WIDTH  engine exponent operand
- eng_mod  out  WIDTH  engine modulus operand
- eng_done  in  1  engine result valid, one-cycle pulse
- eng_res  in  OUT_W  engine result
- pub_vld  out  1  local public key valid (level)
- pub_key  out  WIDTH  local public key
- OUT  out  OUT_W  shared secret
- out_vld  out  1  shared secret valid (level)
- busy  out  1  exchange in progress
- err  out  1  run aborted (timeout or argument fault)

Behaviour:
- Reset (RST low, asynchronous): state IDLE. All outputs 0, including eng_start, pub_vld, out_vld, busy, err, pub_key, OUT and the operand outputs. Peer latch cleared. ST edge register cleared.
- ST edge: st_q is a registered copy of ST; start = ST & ~st_q. Start is accepted only in IDLE, DONE or ERR and is ignored otherwise.
- Accepting start:
  - latch G, P, X
  - clear pub_vld, out_vld, err and the peer latch
  - set busy
  - go to PUB_GO
- PUB_GO (1 cycle):
  - eng_start=1 with eng_base=G, eng_exp=X, eng_mod=P
  - timeout counter cleared
  - go to PUB_WAIT
- PUB_WAIT:
  - counter increments each cycle
  - eng_done: pub_key <= eng_res[WIDTH-1:0], pub_vld <= 1, go to PEER
  - counter == TMO_MAX without eng_done: go to ERR
- PEER:
  - if the peer latch is full, or peer_vld is high this cycle, go to SEC_GO
  - otherwise wait indefinitely; there is no timeout in PEER
- Peer latch:
  - while busy, the first cycle with peer_vld=1 captures peer_pub
  - later peer_vld pulses in the same run are ignored
  - peer_vld in IDLE/DONE/ERR is ignored
  - a peer key arriving before phase 1 completes is kept
- SEC_GO (1 cycle): eng_start=1 with eng_base=latched Y, eng_exp=X, eng_mod=P; counter cleared.
- SEC_WAIT:
  - eng_done: OUT <= eng_res, out_vld <= 1, go to DONE
  - timeout: go to ERR
- DONE: busy=0; pub_vld, out_vld, pub_key and OUT hold until the next accepted start or reset.
- ERR:
  - err=1, busy=0, out_vld=0
  - pub_vld keeps its value, so a phase-2 timeout still shows a valid public key
- Operand outputs hold their last values while the engine runs. eng_done outside PUB_WAIT/SEC_WAIT is ignored.
- Latency with an engine of latency L (eng_done L cycles after eng_start):
  - eng_start is asserted the cycle after the start edge
  - pub_vld rises L+1 cycles after eng_start
  - out_vld rises L+2 cycles after the phase-2 eng_start, counting from PEER with the peer key present

Optional Feature:
- Macro: DH_ARG_CHECK_EN
- Defined: on an accepted start, if P < 2, G == 0, G >= P or X == 0, the FSM goes directly to ERR next cycle with err=1. eng_start is never pulsed.
- Undefined: no argument check; any operands are passed to the engine.

Test Plan:
- Nominal, peer late:
  - stimulus: G=5, P=23, X=6; engine model latency 10; ST rises; peer_pub=19 pulsed 5 cycles after pub_vld
  - expect: one eng_start (5,6,23); pub_key=8, pub_vld=1; second eng_start (19,6,23); OUT=2, out_vld=1, busy=0, err=0
- Peer early:
  - stimulus: same operands; peer_vld pulsed 2 cycles after start, before phase 1 completes
  - expect: peer key kept; SEC_GO follows PEER immediately; OUT=2
- Timeout:
  - stimulus: TMO_MAX=20; engine never asserts eng_done
  - expect: err=1 and busy=0 about 21 cycles after eng_start; pub_vld=0; a new ST edge restarts a clean run
- Ignored starts:
  - stimulus: ST toggled and extra peer_vld pulses (Y=7) issued mid-run
  - expect: no extra eng_start; OUT still 2 using Y=19
- Reset mid-run:
  - stimulus: RST driven low during SEC_WAIT
  - expect: all outputs 0 immediately (asynchronous); after release, ST edge runs a full exchange correctly
- DH_ARG_CHECK_EN:
  - stimulus: P=1, then separately G=23 with P=23
  - expect: err=1 one cycle after start; eng_start stays 0; with the macro undefined, eng_start pulses instead

Source files
------------

// File: rtl/dh_exchange_sequencer.sv
// Sequences one Diffie-Hellman exchange (G^X mod P, then Y^X mod P) through a shared modexp engine.
// Optional DH_ARG_CHECK_EN: reject degenerate operands on start and go straight to ERR.
module dh_exchange_sequencer #(
  parameter int          WIDTH   = 32,
  parameter int          OUT_W   = 48,
  parameter int          TMO_W   = 16,
  parameter int unsigned TMO_MAX = 16'hFFFF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ST,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] X,
  input  logic             peer_vld,
  input  logic [WIDTH-1:0] peer_pub,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_base,
  output logic [WIDTH-1:0] eng_exp,
  output logic [WIDTH-1:0] eng_mod,
  input  logic             eng_done,
  input  logic [OUT_W-1:0] eng_res,
  output logic             pub_vld,
  output logic [WIDTH-1:0] pub_key,
  output logic [OUT_W-1:0] OUT,
  output logic             out_vld,
  output logic             busy,
  output logic             err,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_PUB_GO, S_PUB_WAIT, S_PEER, S_SEC_GO, S_SEC_WAIT, S_DONE, S_ERR
  } state_t;

  localparam logic [TMO_W-1:0] LP_TMO = TMO_W'(TMO_MAX);

  state_t             r_state;
  logic               r_st_q;
  logic [WIDTH-1:0]   r_y;
  logic               r_y_full;
  logic [TMO_W-1:0]   r_cnt;
  logic               w_start;
  logic               w_arg_ok;

  assign w_start   = ST & ~r_st_q;
  assign dbg_state = r_state;

`ifdef DH_ARG_CHECK_EN
  assign w_arg_ok = !((P < WIDTH'(2)) || (G == '0) || (G >= P) || (X == '0));
`else
  assign w_arg_ok = 1'b1;
`endif

  // Engine handshake: eng_start is a one-cycle request whose operands stay stable until the
  // next request; eng_done is a one-cycle response taken only in a WAIT state; no backpressure.
  // The operand outputs double as the latched copies of G, X and P for the whole run.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_st_q    <= 1'b0;
      r_y       <= '0;
      r_y_full  <= 1'b0;
      r_cnt     <= '0;
      eng_start <= 1'b0;
      eng_base  <= '0;
      eng_exp   <= '0;
      eng_mod   <= '0;
      pub_vld   <= 1'b0;
      pub_key   <= '0;
      OUT       <= '0;
      out_vld   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_st_q    <= ST;
      eng_start <= 1'b0;
      // First peer key of a run wins, even if it arrives during phase 1.
      if (busy && peer_vld && !r_y_full) begin
        r_y      <= peer_pub;
        r_y_full <= 1'b1;
      end
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_start) begin
            pub_vld  <= 1'b0;
            out_vld  <= 1'b0;
            err      <= 1'b0;
            r_y_full <= 1'b0;
            eng_base <= G;
            eng_exp  <= X;
            eng_mod  <= P;
            if (w_arg_ok) begin
              busy      <= 1'b1;
              eng_start <= 1'b1;
              r_state   <= S_PUB_GO;
            end else begin
              err     <= 1'b1;
              r_state <= S_ERR;
            end
          end
        end
        S_PUB_GO: begin
          r_cnt   <= '0;
          r_state <= S_PUB_WAIT;
        end
        S_PUB_WAIT: begin
          if (eng_done) begin
            pub_key <= eng_res[WIDTH-1:0];
            pub_vld <= 1'b1;
            r_state <= S_PEER;
          end else if (r_cnt == LP_TMO) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            out_vld <= 1'b0;
            r_state <= S_ERR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PEER: begin
          if (r_y_full || peer_vld) begin
            eng_start <= 1'b1;
            eng_base  <= r_y_full ? r_y : peer_pub;
            r_state   <= S_SEC_GO;
          end
        end
        S_SEC_GO: begin
          r_cnt   <= '0;
          r_state <= S_SEC_WAIT;
        end
        S_SEC_WAIT: begin
          if (eng_done) begin
            OUT     <= eng_res;
            out_vld <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else if (r_cnt == LP_TMO) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            out_vld <= 1'b0;
            r_state <= S_ERR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dh_exchange_sequencer.sv
// Bench for dh_exchange_sequencer: behavioural modexp engine, arithmetic reference model, scenario tasks.
module tb_dh_exchange_sequencer;
  localparam int WIDTH   = 32;
  localparam int OUT_W   = 48;
  localparam int TMO_W   = 16;
  localparam int TMO_MAX = 20;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             ST = 1'b0;
  logic [WIDTH-1:0] G = '0, P = '0, X = '0;
  logic             peer_vld = 1'b0;
  logic [WIDTH-1:0] peer_pub = '0;
  logic             eng_start;
  logic [WIDTH-1:0] eng_base, eng_exp, eng_mod;
  logic             eng_done = 1'b0;
  logic [OUT_W-1:0] eng_res = '0;
  logic             pub_vld;
  logic [WIDTH-1:0] pub_key;
  logic [OUT_W-1:0] OUT;
  logic             out_vld, busy, err;
  logic [2:0]       dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  dh_exchange_sequencer #(.WIDTH(WIDTH), .OUT_W(OUT_W), .TMO_W(TMO_W), .TMO_MAX(TMO_MAX)) dut (
    .CLK(CLK), .RST(RST), .ST(ST), .G(G), .P(P), .X(X),
    .peer_vld(peer_vld), .peer_pub(peer_pub),
    .eng_start(eng_start), .eng_base(eng_base), .eng_exp(eng_exp), .eng_mod(eng_mod),
    .eng_done(eng_done), .eng_res(eng_res),
    .pub_vld(pub_vld), .pub_key(pub_key), .OUT(OUT), .out_vld(out_vld),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- reference arithmetic ----------------
  function automatic logic [63:0] modexp(input logic [63:0] b, input logic [63:0] e, input logic [63:0] m);
    logic [63:0] r;
    if (m == 0) return 64'd0;
    r = 64'd1 % m;
    b = b % m;
    while (e != 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  // ---------------- behavioural engine (drives on negedge) ----------------
  bit               eng_respond = 1'b1;
  int               eng_lat = 10;
  int               eng_cnt = 0;
  int               start_cnt = 0;
  logic [OUT_W-1:0] eng_pend = '0;
  logic [3*WIDTH-1:0] obs_q[$];

  always @(negedge CLK) begin
    eng_done = 1'b0;
    if (!RST) begin
      eng_cnt = 0;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt = eng_cnt - 1;
        if (eng_cnt == 0) begin
          eng_done = 1'b1;
          eng_res  = eng_pend;
        end
      end
      if (eng_start) begin
        start_cnt = start_cnt + 1;
        obs_q.push_back({eng_base, eng_exp, eng_mod});
        if (eng_respond) begin
          eng_cnt  = eng_lat;
          eng_pend = OUT_W'(modexp(64'(eng_base), 64'(eng_exp), 64'(eng_mod)));
        end
      end
    end
  end

  // ---------------- scoreboard state ----------------
  logic [OUT_W-1:0] exp_q[$];
  int pub_seen, sec_seen, out_seen, err_seen, peer_cyc;
  bit go0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic reset_pulse();
    RST = 1'b0;
    tick(2);
    RST = 1'b1;
    tick(1);
  endtask

  // Drives one exchange; cycle 0 is the cycle after the accepted start edge.
  task automatic drive_run(input int peer_at, input bit rel_pub, input logic [WIDTH-1:0] y, input bit noise);
    bit fire;
    start_cnt = 0;
    obs_q.delete();
    ST = 1'b1;
    tick(1);
    ST = 1'b0;
    go0 = eng_start;
    pub_seen = -1; sec_seen = -1; out_seen = -1; err_seen = -1; peer_cyc = -1;
    for (int j = 0; j < 300; j++) begin
      fire = rel_pub ? (pub_seen >= 0 && j == pub_seen + peer_at) : (j == peer_at);
      peer_vld = fire || (noise && peer_cyc >= 0 && (j % 3) == 0);
      peer_pub = fire ? y : 32'd7;
      if (fire) peer_cyc = j;
      if (noise) ST = ((j / 2) % 2) == 1;
      tick(1);
      peer_vld = 1'b0;
      if (pub_vld && pub_seen < 0) pub_seen = j + 1;
      if (eng_start && sec_seen < 0) sec_seen = j + 1;
      if (out_vld) begin out_seen = j + 1; break; end
      if (err) begin err_seen = j + 1; break; end
    end
    ST = 1'b0;
    peer_vld = 1'b0;
    tick(1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b0;
    tick(2);
    n_cmp++; if ({eng_start, pub_vld, out_vld, busy, err} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 00000", {eng_start, pub_vld, out_vld, busy, err}); end
    n_cmp++; if ({eng_base, eng_exp, eng_mod} !== '0) begin
      n_err++; $display("FAIL reset_operands: got %h expected 0", {eng_base, eng_exp, eng_mod}); end
    n_cmp++; if ({pub_key, OUT} !== '0) begin
      n_err++; $display("FAIL reset_results: got %h expected 0", {pub_key, OUT}); end
    RST = 1'b1;
    tick(2);
    n_cmp++; if ({busy, err, eng_start} !== 3'b0) begin
      n_err++; $display("FAIL reset_idle: got %b expected 000", {busy, err, eng_start}); end
  endtask

  task automatic test_nominal();
    logic [OUT_W-1:0] e;
    G = 5; P = 23; X = 6; eng_lat = 10; eng_respond = 1'b1;
    exp_q.push_back(OUT_W'(modexp(5, 6, 23)));
    exp_q.push_back(OUT_W'(modexp(19, 6, 23)));
    drive_run(5, 1'b1, 32'd19, 1'b0);
    n_cmp++; if (go0 !== 1'b1) begin n_err++; $display("FAIL nom_start_latency: got %b expected 1", go0); end
    n_cmp++; if (obs_q.size() != 2) begin n_err++; $display("FAIL nom_start_count: got %0d expected 2", obs_q.size()); end
    else begin
      n_cmp++; if (obs_q[0] !== {32'd5, 32'd6, 32'd23}) begin n_err++; $display("FAIL nom_ops1: got %h expected 5,6,23", obs_q[0]); end
      n_cmp++; if (obs_q[1] !== {32'd19, 32'd6, 32'd23}) begin n_err++; $display("FAIL nom_ops2: got %h expected 19,6,23", obs_q[1]); end
    end
    n_cmp++; if (pub_seen != eng_lat + 1) begin n_err++; $display("FAIL nom_pub_latency: got %0d expected %0d", pub_seen, eng_lat + 1); end
    e = exp_q.pop_front();
    n_cmp++; if ({16'd0, pub_key} !== e || pub_vld !== 1'b1) begin n_err++; $display("FAIL nom_pub_key: got %0d/%b expected %0d/1", pub_key, pub_vld, e); end
    n_cmp++; if (sec_seen != peer_cyc + 1) begin n_err++; $display("FAIL nom_sec_start: got %0d expected %0d", sec_seen, peer_cyc + 1); end
    n_cmp++; if (out_seen != peer_cyc + eng_lat + 2) begin n_err++; $display("FAIL nom_out_latency: got %0d expected %0d", out_seen, peer_cyc + eng_lat + 2); end
    e = exp_q.pop_front();
    n_cmp++; if (OUT !== e || out_vld !== 1'b1) begin n_err++; $display("FAIL nom_secret: got %0d/%b expected %0d/1", OUT, out_vld, e); end
    n_cmp++; if ({busy, err} !== 2'b00) begin n_err++; $display("FAIL nom_done_flags: got busy=%b err=%b expected 0 0", busy, err); end
  endtask

  task automatic test_peer_early();
    logic [OUT_W-1:0] e;
    G = 5; P = 23; X = 6; eng_lat = 10;
    e = OUT_W'(modexp(19, 6, 23));
    drive_run(1, 1'b0, 32'd19, 1'b0);
    n_cmp++; if (sec_seen != pub_seen + 1) begin n_err++; $display("FAIL early_sec_start: got %0d expected %0d", sec_seen, pub_seen + 1); end
    n_cmp++; if (out_seen != pub_seen + eng_lat + 2) begin n_err++; $display("FAIL early_out_latency: got %0d expected %0d", out_seen, pub_seen + eng_lat + 2); end
    n_cmp++; if (OUT !== e) begin n_err++; $display("FAIL early_secret: got %0d expected %0d", OUT, e); end
  endtask

  task automatic test_ignored_starts();
    logic [OUT_W-1:0] e;
    G = 5; P = 23; X = 6; eng_lat = 10;
    e = OUT_W'(modexp(19, 6, 23));
    drive_run(3, 1'b0, 32'd19, 1'b1);
    n_cmp++; if (start_cnt != 2) begin n_err++; $display("FAIL ign_start_count: got %0d expected 2", start_cnt); end
    n_cmp++; if (obs_q.size() != 2 || obs_q[obs_q.size()-1][3*WIDTH-1:2*WIDTH] !== 32'd19) begin
      n_err++; $display("FAIL ign_peer_base: got %0d entries expected second base 19", obs_q.size()); end
    n_cmp++; if (OUT !== e || out_vld !== 1'b1) begin n_err++; $display("FAIL ign_secret: got %0d/%b expected %0d/1", OUT, out_vld, e); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] y;
    logic [OUT_W-1:0] e_pub, e_sec;
    int pe, pat;
    for (int k = 0; k < 6; k++) begin
      P = $urandom_range(32'hFFFF_FFFF, 3);
      G = $urandom_range(P - 1, 1);
      X = $urandom_range(32'hFFFF_FFFF, 1);
      y = $urandom_range(P - 1, 1);
      eng_lat = $urandom_range(15, 2);
      pat = $urandom_range(30, 1);
      e_pub = OUT_W'(modexp(64'(G), 64'(X), 64'(P)));
      e_sec = OUT_W'(modexp(64'(y), 64'(X), 64'(P)));
      drive_run(pat, 1'b0, y, 1'b0);
      pe = (peer_cyc > pub_seen) ? peer_cyc : pub_seen;
      n_cmp++; if ({16'd0, pub_key} !== e_pub || pub_seen != eng_lat + 1) begin
        n_err++; $display("FAIL rnd_pub[%0d]: got %0d@%0d expected %0d@%0d", k, pub_key, pub_seen, e_pub, eng_lat + 1); end
      n_cmp++; if (OUT !== e_sec || out_seen != pe + eng_lat + 2) begin
        n_err++; $display("FAIL rnd_secret[%0d]: got %0d@%0d expected %0d@%0d", k, OUT, out_seen, e_sec, pe + eng_lat + 2); end
    end
  endtask

  task automatic test_timeout();
    logic [OUT_W-1:0] e;
    G = 5; P = 23; X = 6; eng_lat = 10; eng_respond = 1'b0;
    drive_run(1000, 1'b0, 32'd19, 1'b0);
    // counter is 0 in the first WAIT cycle and reaches TMO_MAX TMO_MAX cycles later
    n_cmp++; if (err_seen != TMO_MAX + 2) begin n_err++; $display("FAIL tmo_latency: got %0d expected %0d", err_seen, TMO_MAX + 2); end
    n_cmp++; if ({err, busy, pub_vld, out_vld} !== 4'b1000) begin
      n_err++; $display("FAIL tmo_flags: got err,busy,pub,out=%b expected 1000", {err, busy, pub_vld, out_vld}); end
    n_cmp++; if (start_cnt != 1) begin n_err++; $display("FAIL tmo_start_count: got %0d expected 1", start_cnt); end
    eng_respond = 1'b1;
    e = OUT_W'(modexp(19, 6, 23));
    drive_run(4, 1'b0, 32'd19, 1'b0);
    n_cmp++; if (go0 !== 1'b1 || OUT !== e || err !== 1'b0) begin
      n_err++; $display("FAIL tmo_restart: got start=%b out=%0d err=%b expected 1 %0d 0", go0, OUT, err, e); end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    logic [OUT_W-1:0] e;
    G = 5; P = 23; X = 6; eng_lat = 10;
    start_cnt = 0;
    ST = 1'b1; tick(1); ST = 1'b0;
    peer_vld = 1'b1; peer_pub = 32'd19; tick(1); peer_vld = 1'b0;
    cyc = 0;
    while (start_cnt < 2 && cyc < 100) begin tick(1); cyc++; end
    n_cmp++; if (start_cnt != 2) begin n_err++; $display("FAIL mid_reach_sec: got %0d starts expected 2", start_cnt); end
    tick(3);
    RST = 1'b0;
    #1;
    n_cmp++; if ({eng_start, pub_vld, out_vld, busy, err} !== 5'b0 || {pub_key, OUT} !== '0) begin
      n_err++; $display("FAIL mid_async_flags: got %b key=%0d out=%0d expected 00000 0 0", {eng_start, pub_vld, out_vld, busy, err}, pub_key, OUT); end
    n_cmp++; if ({eng_base, eng_exp, eng_mod} !== '0) begin
      n_err++; $display("FAIL mid_async_operands: got %h expected 0", {eng_base, eng_exp, eng_mod}); end
    tick(2);
    RST = 1'b1;
    tick(1);
    e = OUT_W'(modexp(19, 6, 23));
    drive_run(2, 1'b0, 32'd19, 1'b0);
    n_cmp++; if (OUT !== e || {16'd0, pub_key} !== OUT_W'(modexp(5, 6, 23))) begin
      n_err++; $display("FAIL mid_rerun: got out=%0d key=%0d expected %0d %0d", OUT, pub_key, e, modexp(5, 6, 23)); end
  endtask

  task automatic test_arg_check();
    logic [WIDTH-1:0] gs[2];
    logic [WIDTH-1:0] ps[2];
    gs[0] = 32'd5;  ps[0] = 32'd1;
    gs[1] = 32'd23; ps[1] = 32'd23;
    for (int k = 0; k < 2; k++) begin
      G = gs[k]; P = ps[k]; X = 6;
      start_cnt = 0;
      ST = 1'b1; tick(1); ST = 1'b0;
`ifdef DH_ARG_CHECK_EN
      n_cmp++; if ({err, eng_start, busy} !== 3'b100) begin
        n_err++; $display("FAIL arg_reject[%0d]: got err,start,busy=%b expected 100", k, {err, eng_start, busy}); end
      tick(3);
      n_cmp++; if (start_cnt != 0) begin n_err++; $display("FAIL arg_no_start[%0d]: got %0d expected 0", k, start_cnt); end
`else
      n_cmp++; if ({err, eng_start, busy} !== 3'b011) begin
        n_err++; $display("FAIL arg_pass[%0d]: got err,start,busy=%b expected 011", k, {err, eng_start, busy}); end
      tick(3);
      n_cmp++; if (start_cnt != 1) begin n_err++; $display("FAIL arg_start_count[%0d]: got %0d expected 1", k, start_cnt); end
`endif
      reset_pulse();
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_peer_early();
    test_ignored_starts();
    test_random();
    test_timeout();
    test_reset_midrun();
    test_arg_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
